uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter FREQUENCY, default 20_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, serial bit rate; CLKS_PER_BIT = FREQUENCY / BAUD_RATE (integer divide).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, TX buffer depth in bytes; power of two, at least 2.
REQ-004 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port tx_data  input  8  byte to transmit.
REQ-007 SHALL have port tx_valid  input  1  tx_data is valid this cycle.
REQ-008 SHALL have port tx_ready  output  1  buffer can accept a byte (high exactly when the FIFO is not full and reset is high).
REQ-009 SHALL have port tx_serial  output  1  registered serial line, idle high.
REQ-010 SHALL have port tx_busy  output  1  high when not in IDLE or the FIFO is not empty.
REQ-011 SHALL have port tx_done  output  1  one-cycle pulse when a stop bit completes.

Function
REQ-012 SHALL push tx_data into the FIFO on every edge where tx_valid and tx_ready are both high; tx_data SHALL be ignored otherwise.
REQ-013 SHALL use FIFO pointers one bit wider than log2(FIFO_DEPTH), wrapping modulo 2*FIFO_DEPTH; full = MSBs differ and low bits equal; empty = pointers equal.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP and CLEANUP.
REQ-015 IDLE: tx_serial high, counters cleared; if the FIFO is not empty, pop the head byte into a shift register and go to START.
REQ-016 START: tx_serial low for CLKS_PER_BIT cycles, then go to DATA.
REQ-017 DATA: send bits LSB first, each for CLKS_PER_BIT cycles; a 3-bit index counts 0..7; after bit 7 go to PARITY if enabled, else STOP.
REQ-018 STOP: tx_serial high for CLKS_PER_BIT cycles; on the final cycle assert tx_done for exactly one cycle and go to CLEANUP.
REQ-019 CLEANUP: tx_serial high for one cycle, then go to IDLE.
REQ-020 With the FSM in IDLE and the FIFO empty, a byte accepted at edge N SHALL drive tx_serial low from edge N+2.
REQ-021 Back-to-back frames SHALL be separated by exactly 2 extra high cycles (CLEANUP + IDLE) after the stop bit.
REQ-022 A push and a pop on the same edge SHALL both take effect, leaving the occupancy unchanged.
REQ-023 Each bit-period counter SHALL count 0..CLKS_PER_BIT-1 and clear on every bit transition.
REQ-024 An illegal state encoding SHALL return to IDLE on the next edge.

Reset
REQ-025 While reset is low at an edge: state IDLE, tx_serial 1, FIFO emptied, counters 0, tx_done 0, tx_ready 0, tx_busy 0.
REQ-026 Reset mid-frame SHALL abort the frame; tx_serial SHALL be high on the next edge with no partial stop or tx_done.
REQ-027 tx_ready SHALL go high on the first edge after reset returns high.

Configuration
REQ-028 With UART_TX_PARITY_EN defined, the PARITY state SHALL send the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles between DATA and STOP; a frame SHALL be 11 bit periods.
REQ-029 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent; a frame SHALL be 10 bit periods.

Structure
REQ-030 SHALL place the state enum typedef and the CLKS_PER_BIT computation function in shared package uart_pkg, which uart_rx may also import.
REQ-031 SHALL implement the buffer as sub-module uart_tx_fifo (parameter DEPTH, 8-bit data, push/pop, full/empty flags).

Verification (FREQUENCY=1000, BAUD_RATE=100, CLKS_PER_BIT=10)
REQ-032 Push 0xA5 while idle -> tx_serial from edge N+2 is 0,1,0,1,0,0,1,0,1,1 at 10 cycles each; tx_done pulses once at the end of the stop bit.
REQ-033 Push 0x00, 0xFF, 0x3C and 0x81 back-to-back with DEPTH 4 -> tx_ready low after the 4th push; four frames sent in order with 2-cycle gaps.
REQ-034 Hold tx_valid high continuously with 6 bytes -> exactly 6 frames; no byte dropped or duplicated across pointer wrap.
REQ-035 Assert reset at cycle 35 of an 0x55 frame -> tx_serial 1 on the next edge; FIFO empty; no tx_done; clean 0x12 frame after release.
REQ-036 UART_TX_PARITY_EN defined, push 0x07 -> parity bit 1; 11-bit frame.
REQ-037 Loop tx_serial into uart_rx with matching parameters and send 0x00..0xFF -> rx_byte matches each byte.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and bit-timing helper (PARITY state present only with UART_TX_PARITY_EN)
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY  = 3'd3,
`endif
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } uart_state_t;
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO with wrap-bit pointers for the UART transmitter
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [7:0] mem [DEPTH];
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign dout  = mem[rp[AW-1:0]];
  // pointer update; push and pop on the same edge both take effect
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
  // storage write, no reset needed since reads are gated by empty
  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for an even-parity bit (8E1)
module uart_tx import uart_pkg::*; #(
  parameter int FREQUENCY  = 20_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int CPB = clks_per_bit(FREQUENCY, BAUD_RATE);
  localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  uart_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n, fifo_dout;
  logic ser_n, done_n, pop, full, empty, last;
  assign tx_ready = !full && reset;
  assign tx_busy  = (state != IDLE) || !empty;
  assign last     = cnt == LAST;
  assign cnt_inc  = last ? '0 : cnt + 1'b1;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_valid && tx_ready),
    .pop   (pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );
  // next-state and line value; the line is registered so it lags the state by one cycle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    ser_n   = 1'b1;
    done_n  = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          sh_n    = fifo_dout;
          state_n = START;
        end
      end
      START: begin
        ser_n   = 1'b0;
        cnt_n   = cnt_inc;
        state_n = last ? DATA : START;
      end
      DATA: begin
        ser_n = sh[idx];
        cnt_n = cnt_inc;
        if (last) begin
          idx_n = idx + 3'd1;
`ifdef UART_TX_PARITY_EN
          state_n = (idx == 3'd7) ? PARITY : DATA;
`else
          state_n = (idx == 3'd7) ? STOP : DATA;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        ser_n   = ^sh;
        cnt_n   = cnt_inc;
        state_n = last ? STOP : PARITY;
      end
`endif
      STOP: begin
        cnt_n   = cnt_inc;
        done_n  = last;
        state_n = last ? CLEANUP : STOP;
      end
      CLEANUP: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = IDLE;
      end
    endcase
  end
  // state and output registers; reset aborts any frame in progress
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      tx_serial <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      sh        <= sh_n;
      tx_serial <= ser_n;
      tx_done   <= done_n;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx at 10 clocks per bit
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, tx_serial, tx_busy, tx_done;
  int checks = 0;
  int errors = 0;
  logic [7:0] rxq[$];
  logic [7:0] mon_b;
  logic [7:0] hold_b [6] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};

  uart_tx #(.FREQUENCY(1000), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  // expects the start bit on the next sampled edge, then the two idle gap cycles
  task automatic frame_chk(input string tag, input logic [7:0] b);
    logic [10:0] f;
    logic [1:0] e;
    f = frame_bits(b);
    for (int j = 0; j < NB * 10; j++) begin
      tick();
      e = {f[j / 10], (j == NB * 10 - 1)};
      chk(tag, {tx_serial, tx_done}, e);
    end
    repeat (2) begin
      tick();
      chk({tag, " gap"}, {tx_serial, tx_done}, 2'b10);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!tx_done && n < 400);
    chk(tag, tx_done, 1'b1);
  endtask

  // line monitor: samples mid-bit and records each decoded data byte
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (reset && tx_serial === 1'b0) begin
        repeat (4) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(posedge clk);
          #2;
          mon_b[i] = tx_serial;
        end
        repeat ((NB - 9) * 10) @(posedge clk);
        rxq.push_back(mon_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int i, cyc;
    logic acc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_serial", tx_serial, 1'b1);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_ready", tx_ready, 1'b0);
    chk("rst_busy", tx_busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("ready_after_rst", tx_ready, 1'b1);
    chk("idle_busy", tx_busy, 1'b0);

    push(8'hA5);
    tick();
    chk("a5_latency", tx_serial, 1'b1);
    frame_chk("a5", 8'hA5);
    chk("a5_busy_end", tx_busy, 1'b0);
`ifdef UART_TX_PARITY_EN
    push(8'h07);
    tick();
    chk("p07_latency", tx_serial, 1'b1);
    frame_chk("p07", 8'h07);
`endif

    push(8'h11);
    chk("ready_11", tx_ready, 1'b1);
    push(8'h00);
    chk("ready_00", tx_ready, 1'b1);
    push(8'hFF);
    chk("ready_ff", tx_ready, 1'b1);
    push(8'h3C);
    chk("ready_3c", tx_ready, 1'b1);
    push(8'h81);
    chk("ready_full", tx_ready, 1'b0);
    chk("busy_full", tx_busy, 1'b1);
    @(negedge clk);
    tx_data  = 8'hEE;
    tx_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("ready_held", tx_ready, 1'b0);
    end
    tx_valid = 1'b0;
    wait_done("done_11");
    repeat (2) begin
      tick();
      chk("gap_11", {tx_serial, tx_done}, 2'b10);
    end
    frame_chk("b2b_00", 8'h00);
    frame_chk("b2b_ff", 8'hFF);
    frame_chk("b2b_3c", 8'h3C);
    frame_chk("b2b_81", 8'h81);
    chk("b2b_busy_end", tx_busy, 1'b0);

    rxq.delete();
    i = 0;
    cyc = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    while (i < 6 && cyc < 1000) begin
      tx_data = hold_b[i];
      acc = tx_ready;
      @(posedge clk);
      if (acc) i++;
      @(negedge clk);
      cyc++;
    end
    tx_valid = 1'b0;
    chk("hold_accepted", i, 6);
    cyc = 0;
    while (rxq.size() < 6 && cyc < 1000) begin
      tick();
      cyc++;
    end
    repeat (150) tick();
    chk("hold_count", rxq.size(), 6);
    for (int k = 0; k < 6; k++)
      chk("hold_byte", (k < rxq.size()) ? {24'h0, rxq[k]} : 32'hDEAD, {24'h0, hold_b[k]});
    chk("hold_busy_end", tx_busy, 1'b0);

    push(8'h55);
    push(8'h66);
    repeat (36) tick();
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("abort_serial", tx_serial, 1'b1);
    chk("abort_done", tx_done, 1'b0);
    chk("abort_ready", tx_ready, 1'b0);
    chk("abort_busy", tx_busy, 1'b0);
    tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("abort_ready_rel", tx_ready, 1'b1);
    chk("abort_fifo_empty", tx_busy, 1'b0);
    repeat (20) begin
      tick();
      chk("abort_quiet", {tx_serial, tx_done}, 2'b10);
    end
    push(8'h12);
    tick();
    chk("12_latency", tx_serial, 1'b1);
    frame_chk("f12", 8'h12);
    chk("12_busy_end", tx_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
